// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Frame layout: two header bytes (word count N, MSB first) then 4*N payload bytes.
package boot_pkg;

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    PAYLOAD,
    FLUSH,
    DONE,
    ERR
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;

  // Bit offset of the byte lane that receives stream byte idx within a word.
  function automatic logic [4:0] lane_lsb(input logic [1:0] idx, input bit big_endian);
    logic [1:0] lane;
    lane = big_endian ? (2'(BYTES_PER_WORD - 1) - idx) : idx;
    return {lane, 3'b000};
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// slave is the loader side; master is the stream source / memory side.
interface imem_boot_loader_if
  import boot_pkg::*;
#(
  parameter int ADDR_W = 8
);

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [WORD_W-1:0] imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

endinterface

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs accepted stream bytes into 32-bit words; word_vld flags the 4th byte
// combinationally, with word_dat already holding that byte in its lane.
module imem_boot_loader_byte_packer
  import boot_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_vld,
  input  logic [BYTE_W-1:0] byte_dat,
  output logic              word_vld,
  output logic [WORD_W-1:0] word_dat
);

  logic [1:0]        idx_q;
  logic [WORD_W-1:0] word_q;

  always_comb begin
    word_dat = word_q;
    word_dat[lane_lsb(idx_q, BIG_ENDIAN) +: BYTE_W] = byte_dat;
  end

  assign word_vld = byte_vld && (idx_q == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else if (byte_vld) begin
      idx_q  <= idx_q + 2'd1;
      word_q <= word_dat;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a framed byte stream into instruction memory from address 0, holding the core
// in reset until the final write commits; input is refused once the frame is complete.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  imem_boot_loader_if.slave   bus,
  output logic                core_rst,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [15:0]         word_count
);

  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  state_t            state_q, state_d;
  logic [15:0]       n_q;
  logic [15:0]       wc_q;
  logic [15:0]       wc_inc;
  logic [15:0]       hdr_n;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              core_rst_q;
  logic              accept;
  logic              word_vld;
  logic [WORD_W-1:0] word_dat;

  assign bus.in_ready = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == PAYLOAD);
  assign accept       = bus.in_valid && bus.in_ready;
  assign hdr_n        = {n_q[15:8], bus.in_data};
  assign wc_inc       = wc_q + 16'd1;

  imem_boot_loader_byte_packer #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_packer (
    .clk      (clk),
    .rst      (rst),
    .byte_vld (accept && (state_q == PAYLOAD)),
    .byte_dat (bus.in_data),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      HDR_HI:  if (accept) state_d = HDR_LO;
      HDR_LO: begin
        if (accept) begin
          if (hdr_n == 16'd0)               state_d = FLUSH;
          else if ({1'b0, hdr_n} > DEPTH)   state_d = ERR;
          else                              state_d = PAYLOAD;
        end
      end
      PAYLOAD: if (word_vld && (wc_inc == n_q)) state_d = FLUSH;
      // FLUSH exists only so the last write strobe lands before the core is released.
      FLUSH:   state_d = DONE;
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HDR_HI;
      n_q        <= '0;
      wc_q       <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      core_rst_q <= 1'b1;
    end else begin
      state_q <= state_d;
      we_q    <= word_vld;
      if (accept && (state_q == HDR_HI)) n_q[15:8] <= bus.in_data;
      if (accept && (state_q == HDR_LO)) n_q[7:0]  <= bus.in_data;
      if (word_vld) begin
        addr_q  <= wc_q[ADDR_W-1:0];
        wdata_q <= word_dat;
        wc_q    <= wc_inc;
      end
      if (state_d == DONE) core_rst_q <= 1'b0;
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign core_rst       = core_rst_q;
  assign word_count     = wc_q;
  assign busy           = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                          (state_q == PAYLOAD) || (state_q == FLUSH);
  assign done           = (state_q == DONE);
  assign err            = (state_q == ERR);

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream boot stage for the single-cycle MIPS core.
- Receives a program as a byte stream over a valid/ready handshake and packs it into 32-bit words.
- Writes those words into instruction memory from word address 0.
- Holds the core in reset until the last word has committed; then releases the core and stops accepting input.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; DEPTH = 2^ADDR_W words.
- BIG_ENDIAN, 1. When 1, the first byte of each word goes to bits [31:24]. When 0, it goes to bits [7:0].

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can accept a byte; a transfer occurs when in_valid && in_ready at the edge.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  word to write.
- core_rst  out  1  reset to the MIPS core (active-high).
- busy  out  1  in HDR_HI, HDR_LO, PAYLOAD or FLUSH.
- done  out  1  in DONE.
- err  out  1  in ERR.
- word_count  out  16  count of words written so far.

Behaviour:
- Reset values (rst high at edge):
  - state = HDR_HI; core_rst = 1; imem_we = 0; imem_addr = 0; imem_wdata = 0.
  - word_count = 0; byte index = 0; header N = 0; done = 0; err = 0.
  - busy = 1, in_ready = 1 (both combinational from state).
- Reset mid-load:
  - Returns to HDR_HI with all counters cleared.
  - Memory already written is not cleared.
  - A pending imem_we is cancelled.
- Frame format: 2 header bytes giving N (16-bit, always MSB first), then 4*N payload bytes.
- in_ready = 1 only in HDR_HI, HDR_LO and PAYLOAD; 0 in FLUSH, DONE and ERR.
- A byte presented while in_ready = 0 is not consumed.
- State transitions, taken only on an accepted byte unless noted:
  - HDR_HI: capture N[15:8], go to HDR_LO.
  - HDR_LO: capture N[7:0], then:
    - if N == 0: go to FLUSH; no write is issued.
    - else if N > DEPTH: go to ERR.
    - else: go to PAYLOAD.
  - PAYLOAD: place the byte into the word lane selected by byte index (0..3) and BIG_ENDIAN.
    - On the 4th byte: imem_we = 1 for exactly the next cycle, imem_addr = word_count[ADDR_W-1:0], imem_wdata = the full assembled word.
    - On the same edge, word_count increments and byte index wraps to 0.
    - If the incremented word_count == N, go to FLUSH; otherwise stay in PAYLOAD.
  - FLUSH: one cycle, no condition; lets the final write commit. Then go to DONE.
  - DONE: terminal until rst. core_rst = 0 from the edge that enters DONE.
  - ERR: terminal until rst. core_rst stays 1; no further writes.
- Byte-level timing:
  - Back-to-back acceptance: one byte per cycle when in_valid is held high.
  - Gaps in in_valid simply stall the FSM.
- Latency and load time:
  - imem_we asserts 1 cycle after the accepting edge of a word's 4th byte.
  - core_rst falls 2 edges after the last payload byte is accepted.
  - Minimum load time for N words at full rate: 2 + 4N + 2 cycles.
- core_rst is registered, glitch-free, and never reasserts except through rst.
- N == DEPTH is legal and fills memory exactly; imem_addr never wraps within a legal frame.

Decomposition:
- Shared package boot_pkg:
  - state enum {HDR_HI, HDR_LO, PAYLOAD, FLUSH, DONE, ERR}.
  - HDR_BYTES = 2, BYTES_PER_WORD = 4.
- One natural sub-module: byte_packer. It holds the byte index and the lane-insertion register, has BIG_ENDIAN as a parameter, and asserts word_valid on the 4th byte.
- The loader FSM, counters and write/reset outputs stay in imem_boot_loader.

Test Plan:
- Nominal load, BIG_ENDIAN=1: bytes 00 02, 20 08 00 05, AC 08 00 00 at full rate.
  - Two writes: addr 0 = 0x20080005, then addr 1 = 0xAC080000.
  - After the last write: FLUSH for one cycle, then done = 1 and core_rst = 0, with word_count = 2.
- Empty program: header 00 00 -> no imem_we; HDR_LO → FLUSH → DONE; core_rst falls 2 edges after the second byte.
- Oversize, ADDR_W=8: header 01 01 (N = 257) -> err = 1, in_ready = 0, core_rst stays 1, no writes. Header 01 00 (N = 256) is accepted and fills addresses 0..255.
- Handshake stalls: in_valid toggling 1/0 every cycle, plus a 10-cycle gap mid-word -> written data identical to the nominal case; no byte lost or duplicated.
- BIG_ENDIAN=0: payload 11 22 33 44 -> imem_wdata = 0x44332211.
- Reset mid-payload: assert rst after 5 payload bytes, then send a fresh frame 00 01, DE AD BE EF.
  - word_count = 1; addr 0 = 0xDEADBEEF; only one write after the reset.
